// File: rtl/dpd_actuator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dpd_actuator_pkg
//  Description : Shared constants and helpers for the DPD actuator: number of
//                LUT slots, memory depth of the sample history, the LUT index
//                at which addressing switches from mag_a to mag_b, and the
//                symmetric-clip saturation helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package dpd_actuator_pkg;

    localparam int ID_MAX      = 64;   // number of LUT slots
    localparam int LAG_DEPTH   = 8;    // memory depth (lags 0..7)
    localparam int MAG_B_SPLIT = 32;   // LUTs at or above this index use mag_b
    localparam int SAT_W       = 128;  // working width of saturate()

    // Sample lag applied to LUT k.
    function automatic int lag_of(input int k);
        return k % LAG_DEPTH;
    endfunction

    // LUT k is addressed by mag_b instead of mag_a.
    function automatic bit use_mag_b(input int k);
        return k >= MAG_B_SPLIT;
    endfunction

    // Symmetric clip of a signed accumulator to +/-(2**(out_w-1)-1).
    // The most negative code is never produced so that I/Q stay symmetric.
    function automatic logic signed [SAT_W-1:0] saturate(
        input logic signed [SAT_W-1:0] acc,
        input int                      out_w
    );
        logic signed [SAT_W-1:0] lim;
        lim = $signed((SAT_W'(1) << (out_w - 1)) - SAT_W'(1));
        if (acc > lim) begin
            return lim;
        end else if (acc < -lim) begin
            return -lim;
        end else begin
            return acc;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/dpd_actuator_if.sv
`default_nettype none
// ============================================================================
//  Module      : dpd_actuator_if
//  Description : Bundles the sample stream and the LUT configuration port of
//                the DPD actuator.
//                Stream : tu_enable, tu {I,Q}, mag {mag_b,mag_a} -> tx, tx_valid
//                Config : enc, lutIdc, wec, addrc, dinc -> doutc, validc
//                master = sample source / register wrapper, slave = actuator.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dpd_actuator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    import dpd_actuator_pkg::*;

    logic                      tu_enable;
    logic [2*DATA_WIDTH-1:0]   tu;
    logic [2*ADDR_WIDTH-1:0]   mag;
    logic [2*DATA_WIDTH-1:0]   tx;
    logic                      tx_valid;

    logic                      enc;
    logic [ID_MAX-1:0]         lutIdc;
    logic                      wec;
    logic [ADDR_WIDTH-1:0]     addrc;
    logic [DATA_WIDTH-1:0]     dinc;
    logic [DATA_WIDTH-1:0]     doutc;
    logic                      validc;

    modport master (
        output tu_enable, tu, mag, enc, lutIdc, wec, addrc, dinc,
        input  tx, tx_valid, doutc, validc
    );

    modport slave (
        input  tu_enable, tu, mag, enc, lutIdc, wec, addrc, dinc,
        output tx, tx_valid, doutc, validc
    );

endinterface
`default_nettype wire

// File: rtl/dpd_actuator_lut_tap.sv
`default_nettype none
// ============================================================================
//  Module      : dpd_lut_tap
//  Description : One complex-gain LUT with an independent configuration port
//                and datapath port, followed by a complex multiplier.
//                Stage 1 registers the LUT word and the delayed sample,
//                stage 2 registers the complex product term.
//  Ports       : clk, rst            - clock, async active-high reset
//                cfg_we/cfg_re       - qualified config write / read strobes
//                cfg_addr/cfg_din    - config address / write data
//                cfg_dout            - registered config read data
//                dp_addr/dp_x        - datapath address and sample {I,Q}
//                term_i/term_q       - registered product term
//  Revision    : 1.0 - initial release
// ============================================================================
module dpd_lut_tap #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic                         cfg_re,
    input  logic [ADDR_WIDTH-1:0]        cfg_addr,
    input  logic [DATA_WIDTH-1:0]        cfg_din,
    output logic [DATA_WIDTH-1:0]        cfg_dout,
    input  logic [ADDR_WIDTH-1:0]        dp_addr,
    input  logic [2*DATA_WIDTH-1:0]      dp_x,
    output logic signed [DATA_WIDTH+1:0] term_i,
    output logic signed [DATA_WIDTH+1:0] term_q
);
    localparam int c_half   = DATA_WIDTH / 2;
    localparam int c_frac   = c_half - 1;
    localparam int c_prod_w = DATA_WIDTH + c_half;
    localparam int c_term_w = DATA_WIDTH + 2;
    localparam int c_depth  = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]        r_mem [c_depth];
    logic [DATA_WIDTH-1:0]        r_coef;
    logic [2*DATA_WIDTH-1:0]      r_x;
    logic [DATA_WIDTH-1:0]        r_cfg_dout;

    logic signed [DATA_WIDTH-1:0] w_xi, w_xq;
    logic signed [c_half-1:0]     w_ci, w_cq;
    logic signed [c_prod_w-1:0]   w_p_ii, w_p_qq, w_p_iq, w_p_qi;
    logic signed [DATA_WIDTH:0]   w_s_ii, w_s_qq, w_s_iq, w_s_qi;

    // LUT storage is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            r_mem[cfg_addr] <= cfg_din;
        end
    end

    // Reads sample the array before any same-edge write lands, so a
    // coincident write to the same address is seen one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_coef     <= '0;
            r_x        <= '0;
            r_cfg_dout <= '0;
        end else begin
            r_coef <= r_mem[dp_addr];
            r_x    <= dp_x;
            if (cfg_re) begin
                r_cfg_dout <= r_mem[cfg_addr];
            end
        end
    end

    assign cfg_dout = r_cfg_dout;

    assign w_xi = r_x[2*DATA_WIDTH-1:DATA_WIDTH];
    assign w_xq = r_x[DATA_WIDTH-1:0];
    assign w_ci = r_coef[DATA_WIDTH-1:c_half];
    assign w_cq = r_coef[c_half-1:0];

    assign w_p_ii = c_prod_w'(w_xi) * c_prod_w'(w_ci);
    assign w_p_qq = c_prod_w'(w_xq) * c_prod_w'(w_cq);
    assign w_p_iq = c_prod_w'(w_xi) * c_prod_w'(w_cq);
    assign w_p_qi = c_prod_w'(w_xq) * c_prod_w'(w_ci);

    // Each real product is truncated (floor) before the complex combine.
    assign w_s_ii = w_p_ii[c_prod_w-1:c_frac];
    assign w_s_qq = w_p_qq[c_prod_w-1:c_frac];
    assign w_s_iq = w_p_iq[c_prod_w-1:c_frac];
    assign w_s_qi = w_p_qi[c_prod_w-1:c_frac];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            term_i <= '0;
            term_q <= '0;
        end else begin
            term_i <= c_term_w'(w_s_ii) - c_term_w'(w_s_qq);
            term_q <= c_term_w'(w_s_iq) + c_term_w'(w_s_qi);
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpd_actuator.sv
`default_nettype none
// ============================================================================
//  Module      : dpd_actuator
//  Description : Memory-polynomial digital predistortion actuator. Up to 64
//                complex-gain LUTs, each applied to the sample lag(k) samples
//                back, are summed and clipped to form the TX output.
//                Pipeline: LUT read -> multiply -> sum -> saturate (4 cycles).
//  Ports       : clk - sole clock
//                rst - asynchronous active-high reset
//                bus - dpd_actuator_if.slave (sample stream + LUT config)
//  Revision    : 1.0 - initial release
// ============================================================================
module dpd_actuator
    import dpd_actuator_pkg::*;
#(
    parameter logic [ID_MAX-1:0] ID_MASK    = 64'hFFFF_FFFF_FFFF_FFFF,
    parameter int                DATA_WIDTH = 32,
    parameter int                ADDR_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    dpd_actuator_if.slave bus
);
    localparam int c_term_w = DATA_WIDTH + 2;
    localparam int c_acc_w  = DATA_WIDTH + 7;
    localparam int c_lat    = 4;

    // History of enable-qualified samples; index m holds sample n-1-m.
    logic [2*DATA_WIDTH-1:0]    r_hist_x   [LAG_DEPTH-1];
    logic [2*ADDR_WIDTH-1:0]    r_hist_mag [LAG_DEPTH-1];
    logic [2*DATA_WIDTH-1:0]    w_lag_x    [LAG_DEPTH];
    logic [2*ADDR_WIDTH-1:0]    w_lag_mag  [LAG_DEPTH];

    logic signed [c_term_w-1:0] w_term_i   [ID_MAX];
    logic signed [c_term_w-1:0] w_term_q   [ID_MAX];
    logic [DATA_WIDTH-1:0]      w_cfg_dout [ID_MAX];

    logic [c_lat-1:0]           r_vld;
    logic signed [c_acc_w-1:0]  w_sum_i, w_sum_q;
    logic signed [c_acc_w-1:0]  r_sum_i, r_sum_q;
    logic signed [SAT_W-1:0]    w_sat_i, w_sat_q;
    logic [2*DATA_WIDTH-1:0]    r_tx;

    logic                       r_rd_pend;
    logic [ID_MAX-1:0]          r_rd_sel;
    logic [DATA_WIDTH-1:0]      w_rd_data;
    logic                       w_rd_found;
    logic [DATA_WIDTH-1:0]      r_doutc;
    logic                       r_validc;

    // ------------------------------------------------------------------
    // Sample history: advances only on tu_enable so gaps do not age it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int m = 0; m < LAG_DEPTH - 1; m++) begin
                r_hist_x[m]   <= '0;
                r_hist_mag[m] <= '0;
            end
        end else if (bus.tu_enable) begin
            r_hist_x[0]   <= bus.tu;
            r_hist_mag[0] <= bus.mag;
            for (int m = 1; m < LAG_DEPTH - 1; m++) begin
                r_hist_x[m]   <= r_hist_x[m-1];
                r_hist_mag[m] <= r_hist_mag[m-1];
            end
        end
    end

    always_comb begin
        w_lag_x[0]   = bus.tu;
        w_lag_mag[0] = bus.mag;
        for (int m = 1; m < LAG_DEPTH; m++) begin
            w_lag_x[m]   = r_hist_x[m-1];
            w_lag_mag[m] = r_hist_mag[m-1];
        end
    end

    // ------------------------------------------------------------------
    // LUT taps; removed slots contribute zero and read back as zero.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < ID_MAX; k++) begin : g_tap
        if (ID_MASK[k]) begin : g_on
            localparam int c_lag = lag_of(k);
            logic [ADDR_WIDTH-1:0] w_dp_addr;

            if (use_mag_b(k)) begin : g_mag_b
                assign w_dp_addr = w_lag_mag[c_lag][2*ADDR_WIDTH-1:ADDR_WIDTH];
            end else begin : g_mag_a
                assign w_dp_addr = w_lag_mag[c_lag][ADDR_WIDTH-1:0];
            end

            dpd_lut_tap #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH)
            ) u_tap (
                .clk      (clk),
                .rst      (rst),
                .cfg_we   (bus.enc &  bus.wec & bus.lutIdc[k]),
                .cfg_re   (bus.enc & ~bus.wec & bus.lutIdc[k]),
                .cfg_addr (bus.addrc),
                .cfg_din  (bus.dinc),
                .cfg_dout (w_cfg_dout[k]),
                .dp_addr  (w_dp_addr),
                .dp_x     (w_lag_x[c_lag]),
                .term_i   (w_term_i[k]),
                .term_q   (w_term_q[k])
            );
        end else begin : g_off
            assign w_cfg_dout[k] = '0;
            assign w_term_i[k]   = '0;
            assign w_term_q[k]   = '0;
        end
    end

    // ------------------------------------------------------------------
    // Summation of all terms in the wide accumulator, then clip.
    // ------------------------------------------------------------------
    always_comb begin
        w_sum_i = '0;
        w_sum_q = '0;
        for (int k = 0; k < ID_MAX; k++) begin
            w_sum_i = w_sum_i + c_acc_w'(w_term_i[k]);
            w_sum_q = w_sum_q + c_acc_w'(w_term_q[k]);
        end
    end

    assign w_sat_i = saturate(SAT_W'(r_sum_i), DATA_WIDTH);
    assign w_sat_q = saturate(SAT_W'(r_sum_q), DATA_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld   <= '0;
            r_sum_i <= '0;
            r_sum_q <= '0;
            r_tx    <= '0;
        end else begin
            r_vld   <= {r_vld[c_lat-2:0], bus.tu_enable};
            r_sum_i <= w_sum_i;
            r_sum_q <= w_sum_q;
            // tx holds its last value between valid samples.
            if (r_vld[c_lat-2]) begin
                r_tx <= {w_sat_i[DATA_WIDTH-1:0], w_sat_q[DATA_WIDTH-1:0]};
            end
        end
    end

    assign bus.tx       = r_tx;
    assign bus.tx_valid = r_vld[c_lat-1];

    // ------------------------------------------------------------------
    // Config readback: the taps register the word, the lowest-indexed
    // selected tap is muxed out one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data  = '0;
        w_rd_found = 1'b0;
        for (int k = 0; k < ID_MAX; k++) begin
            if (r_rd_sel[k] && !w_rd_found) begin
                w_rd_data  = w_cfg_dout[k];
                w_rd_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_pend <= 1'b0;
            r_rd_sel  <= '0;
            r_doutc   <= '0;
            r_validc  <= 1'b0;
        end else begin
            r_rd_pend <= bus.enc & ~bus.wec;
            r_rd_sel  <= bus.lutIdc & ID_MASK;
            r_validc  <= r_rd_pend;
            if (r_rd_pend) begin
                r_doutc <= w_rd_data;
            end
        end
    end

    assign bus.doutc  = r_doutc;
    assign bus.validc = r_validc;

endmodule
`default_nettype wire

// File: tb/tb_dpd_actuator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpd_actuator
//  Description : Scoreboard bench for dpd_actuator. Drivers push expected
//                {data, cycle} entries; a negedge monitor pops and compares
//                whenever tx_valid / validc is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpd_actuator;
    import dpd_actuator_pkg::*;

    localparam int DW = 32;
    localparam int AW = 4;

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t q_tx[$];
    exp_t q_rd[$];
    exp_t q_rdm[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dpd_actuator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    dpd_actuator_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_m ();

    dpd_actuator #(
        .ID_MASK    (64'hFFFF_FFFF_FFFF_FFFF),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    dpd_actuator #(
        .ID_MASK    (64'h1),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (bus_m.slave)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin : mon
        exp_t e;
        if (bus.tx_valid) begin
            if (q_tx.size() == 0) begin
                check("tx_valid unexpected", bus.tx_valid, 64'd0);
            end else begin
                e = q_tx.pop_front();
                check("tx data", bus.tx, e.data);
                check("tx latency", cyc, e.cyc);
            end
        end
        if (bus.validc) begin
            if (q_rd.size() == 0) begin
                check("validc unexpected", bus.validc, 64'd0);
            end else begin
                e = q_rd.pop_front();
                check("doutc", bus.doutc, e.data);
                check("validc latency", cyc, e.cyc);
            end
        end
        if (bus_m.validc) begin
            if (q_rdm.size() == 0) begin
                check("mask validc unexpected", bus_m.validc, 64'd0);
            end else begin
                e = q_rdm.pop_front();
                check("mask doutc", bus_m.doutc, e.data);
                check("mask validc latency", cyc, e.cyc);
            end
        end
    end

    // ---------------------------------------------------------------- drivers
    task automatic clear_all();
        bus.tu_enable   = 1'b0;
        bus.tu          = '0;
        bus.mag         = '0;
        bus.enc         = 1'b0;
        bus.wec         = 1'b0;
        bus.lutIdc      = '0;
        bus.addrc       = '0;
        bus.dinc        = '0;
        bus_m.tu_enable = 1'b0;
        bus_m.tu        = '0;
        bus_m.mag       = '0;
        bus_m.enc       = 1'b0;
        bus_m.wec       = 1'b0;
        bus_m.lutIdc    = '0;
        bus_m.addrc     = '0;
        bus_m.dinc      = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            clear_all();
        end
    endtask

    task automatic cfg_write(input logic [63:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        clear_all();
        bus.enc = 1'b1; bus.wec = 1'b1; bus.lutIdc = sel; bus.addrc = a; bus.dinc = d;
    endtask

    task automatic cfg_read(input logic [63:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        @(negedge clk);
        clear_all();
        bus.enc = 1'b1; bus.wec = 1'b0; bus.lutIdc = sel; bus.addrc = a;
        q_rd.push_back('{data: 64'(exp), cyc: cyc + 2});
    endtask

    task automatic mcfg_write(input logic [63:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        clear_all();
        bus_m.enc = 1'b1; bus_m.wec = 1'b1; bus_m.lutIdc = sel; bus_m.addrc = a; bus_m.dinc = d;
    endtask

    task automatic mcfg_read(input logic [63:0] sel, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        @(negedge clk);
        clear_all();
        bus_m.enc = 1'b1; bus_m.wec = 1'b0; bus_m.lutIdc = sel; bus_m.addrc = a;
        q_rdm.push_back('{data: 64'(exp), cyc: cyc + 2});
    endtask

    task automatic sample(input logic [DW-1:0] xi, input logic [DW-1:0] xq,
                          input logic [AW-1:0] ma, input logic [AW-1:0] mb,
                          input logic [DW-1:0] ei, input logic [DW-1:0] eq);
        @(negedge clk);
        clear_all();
        bus.tu_enable = 1'b1; bus.tu = {xi, xq}; bus.mag = {mb, ma};
        q_tx.push_back('{data: {ei, eq}, cyc: cyc + 4});
    endtask

    // ---------------------------------------------------------------- stimulus
    localparam logic [63:0] SEL_5_40 = 64'h0000_0100_0000_0020;
    localparam logic [63:0] SEL_40   = 64'h0000_0100_0000_0000;
    localparam logic [63:0] SEL_0_32 = 64'h0000_0001_0000_0001;

    initial begin : stim
        logic [DW-1:0] v;
        clear_all();
        repeat (2) @(negedge clk);
        check("reset tx", bus.tx, 64'd0);
        check("reset tx_valid", bus.tx_valid, 64'd0);
        check("reset doutc", bus.doutc, 64'd0);
        check("reset validc", bus.validc, 64'd0);
        rst = 1'b0;
        idle(2);

        // Clear every LUT (broadcast), then load and read back LUT0.
        for (int a = 0; a < 16; a++) cfg_write('1, AW'(a), '0);
        for (int i = 0; i < 16; i++) begin
            v = 32'h1111_1111 * i;
            cfg_write(64'h1, AW'(i), v);
        end
        for (int i = 0; i < 16; i++) begin
            v = 32'h1111_1111 * i;
            cfg_read(64'h1, AW'(i), v);
        end
        cfg_read(64'h0, 4'd5, 32'h0);

        // Broadcast write, single overwrite, lowest-index readback.
        cfg_write(SEL_5_40, 4'd7, 32'hA5A5_0001);
        cfg_write(SEL_40,   4'd7, 32'h5A5A_0002);
        cfg_read(SEL_5_40,  4'd7, 32'hA5A5_0001);
        cfg_read(SEL_40,    4'd7, 32'h5A5A_0002);
        cfg_read(64'h20,    4'd7, 32'hA5A5_0001);
        idle(3);
        for (int a = 0; a < 16; a++) cfg_write('1, AW'(a), '0);

        // Reduced-mask instance: LUT1 absent.
        mcfg_write(64'h3, 4'd2, 32'hCAFE_F00D);
        mcfg_read(64'h2, 4'd2, 32'h0);
        mcfg_read(64'h3, 4'd2, 32'hCAFE_F00D);
        mcfg_read(64'h1, 4'd2, 32'hCAFE_F00D);
        idle(3);

        // Lag-0 gain of 0.5 at LUT0[3].
        cfg_write(64'h1, 4'd3, 32'h4000_0000);
        sample(32'd1000, -32'sd2000, 4'd3, 4'd0, 32'd500, -32'sd1000);
        idle(2);
        sample(-32'sd3, 32'd3, 4'd3, 4'd0, -32'sd2, 32'd1);
        sample(32'd200, -32'sd100, 4'd2, 4'd3, 32'd0, 32'd0);
        idle(5);
        cfg_write(64'h1, 4'd3, '0);

        // Lag-1 LUT1[5]; gap between samples must not age the history.
        cfg_write(64'h2, 4'd5, 32'h4000_0000);
        sample(32'd4000, 32'd0, 4'd5, 4'd0, 32'd0, 32'd0);
        idle(2);
        sample(32'd0, 32'd0, 4'd0, 4'd0, 32'd2000, 32'd0);
        sample(32'd0, 32'd0, 4'd0, 4'd0, 32'd0, 32'd0);
        idle(5);
        cfg_write(64'h2, 4'd5, '0);

        // Two near-unity taps: positive and negative symmetric clip.
        cfg_write(SEL_0_32, 4'd0, 32'h7FFF_0000);
        sample(32'h7FFF_FFFF, 32'd0, 4'd0, 4'd0, 32'h7FFF_FFFF, 32'd0);
        sample(32'h8000_0001, 32'd0, 4'd0, 4'd0, 32'h8000_0001, 32'd0);
        sample(32'h0001_0000, 32'd0, 4'd0, 4'd0, 32'h0001_FFFC, 32'd0);
        idle(5);
        cfg_write(SEL_0_32, 4'd0, '0);

        // Reset in the middle of a 6-sample burst.
        cfg_write(64'h1, 4'd3, 32'h4000_0000);
        for (int k = 1; k <= 6; k++) begin
            sample(32'(200 * k), 32'(-100 * k), 4'd3, 4'd0, 32'(100 * k), 32'(-50 * k));
        end
        @(negedge clk);
        clear_all();
        #2 rst = 1'b1;
        #1;
        check("tx_valid in reset", bus.tx_valid, 64'd0);
        check("tx in reset", bus.tx, 64'd0);
        check("doutc in reset", bus.doutc, 64'd0);
        q_tx.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(10);
        sample(32'd200, -32'sd100, 4'd3, 4'd0, 32'd100, -32'sd50);
        idle(2);

        for (int i = 0; i < 50 && (q_tx.size() + q_rd.size() + q_rdm.size()) > 0; i++) begin
            @(negedge clk);
        end
        check("pending tx", q_tx.size(), 64'd0);
        check("pending reads", q_rd.size() + q_rdm.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
